adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8: operand and result width.
REQ-002 The module SHALL have parameter NUM_REQ, default 4: number of requesters.
REQ-003 The module SHALL have parameter ID_WIDTH, default 2: requester index width, equal to ceil(log2(NUM_REQ)).
REQ-004 clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_a  input  NUM_REQ*DATA_WIDTH  operand A, requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_b  input  NUM_REQ*DATA_WIDTH  operand B, packed the same way as req_a.
REQ-009 req_bypass  input  NUM_REQ  1 = pass-through (result = A), 0 = add.
REQ-010 req_ready  output  NUM_REQ  one-hot grant/accept strobe.
REQ-011 add_a, add_b  output  DATA_WIDTH each  operands driven to the shared adder.
REQ-012 add_clk_en  output  1  drives the shared adder's clk_en.
REQ-013 add_adder_en  output  1  drives the shared adder's adder_en.
REQ-014 add_result  input  DATA_WIDTH  combinational result returned by the shared adder.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  response consumer ready.
REQ-017 rsp_id  output  ID_WIDTH  index of the requester that owns the response.
REQ-018 rsp_data  output  DATA_WIDTH  captured result.
REQ-019 busy  output  1  high in every state other than IDLE.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-021 In IDLE with any req_valid high, the module SHALL grant the first valid requester found scanning from the round-robin pointer upward, modulo NUM_REQ.
REQ-022 In the grant cycle, the module SHALL:
- assert req_ready for the winner only;
- latch its A, B, bypass and index;
- set the pointer to (winner+1) mod NUM_REQ;
- go to EXEC.
REQ-023 In IDLE with no req_valid high, req_ready SHALL be 0 and the state and pointer SHALL be unchanged.
REQ-024 In EXEC, the module SHALL:
- drive add_clk_en=1 and add_adder_en=~latched bypass;
- capture add_result into rsp_data;
- set rsp_valid and rsp_id at the next edge;
- go to RESP.
REQ-025 Outside EXEC, add_clk_en and add_adder_en SHALL be 0.
REQ-026 add_a and add_b SHALL always present the latched operands.
REQ-027 In RESP, rsp_valid, rsp_id and rsp_data SHALL hold stable until the cycle rsp_valid and rsp_ready are both high.
REQ-028 On the rsp_valid/rsp_ready handshake, the module SHALL clear rsp_valid and return to IDLE; no grant SHALL be issued in that same cycle.
REQ-029 req_ready SHALL be 0 in EXEC and RESP; requests SHALL wait and SHALL NOT be dropped.
REQ-030 Latency SHALL be: accept at edge T, rsp_valid high after edge T+2; the maximum rate is one operation per 3 cycles with rsp_ready tied high.
REQ-031 Arithmetic SHALL be modulo 2^DATA_WIDTH with no carry-out; the result width is exactly DATA_WIDTH.
REQ-032 Fairness: a continuously requesting requester SHALL be granted within NUM_REQ grants.
REQ-033 req_valid deasserting after the grant SHALL NOT affect the in-flight operation.
REQ-034 rsp_data SHALL equal the adder output sampled in EXEC; rsp_data and rsp_id SHALL retain their last values after the handshake.

Reset
REQ-035 When rst_n=0 at a clock edge, the module SHALL set:
- state = IDLE and pointer = 0;
- latched operands, rsp_data and rsp_id = 0;
- rsp_valid = 0 and busy = 0.
REQ-036 req_ready, add_clk_en and add_adder_en SHALL be 0 while rst_n=0.
REQ-037 Reset in EXEC or RESP SHALL discard the in-flight operation with no response; the pointer SHALL return to 0.

Verification
REQ-038 Single add: req_valid=0001, A=3, B=5, bypass=0, rsp_ready=1 -> req_ready=0001 at T, add_clk_en=1 and add_adder_en=1 at T+1, rsp_valid=1 with rsp_id=0 and rsp_data=8 after T+2.
REQ-039 Wrap and bypass: A=200, B=100 -> rsp_data=44; then bypass=1, A=7, B=9 -> add_adder_en=0, rsp_data=7.
REQ-040 Round-robin: req_valid=1111 held continuously -> grant order 0,1,2,3,0; no requester granted twice before all four are granted.
REQ-041 Backpressure: rsp_ready=0 for 5 cycles with req_valid=0010 pending -> rsp fields stable, req_ready=0 throughout; rsp_ready=1 -> handshake, IDLE, then requester 1 granted the following cycle.
REQ-042 Reset mid-op: rst_n=0 during EXEC -> next cycle rsp_valid=0, busy=0, pointer=0; no response for the dropped request.
REQ-043 Idle hold: req_valid=0000 for 10 cycles -> req_ready=0, add_clk_en=0, busy=0, pointer unchanged.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one external combinational adder among
// NUM_REQ requesters, returning each result through a valid/ready response port.
module adder_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]            req_bypass,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  output logic                          add_clk_en,
  output logic                          add_adder_en,
  input  logic [DATA_WIDTH-1:0]         add_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  state_t                state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   op_id;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  op_bypass;

  logic [ID_WIDTH:0]     rot_sum [NUM_REQ];
  logic [ID_WIDTH-1:0]   rot_idx [NUM_REQ];
  logic [ID_WIDTH-1:0]   winner;
  logic                  found;
  logic                  grant;

  // rot_idx[k] is the k-th requester visited when scanning upward from ptr
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot_sum[gi] = {1'b0, ptr} + (ID_WIDTH+1)'(gi);
      assign rot_idx[gi] = (rot_sum[gi] >= NUM_REQ_W) ? ID_WIDTH'(rot_sum[gi] - NUM_REQ_W)
                                                      : ID_WIDTH'(rot_sum[gi]);
    end
  endgenerate

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[rot_idx[k]]) begin
        found  = 1'b1;
        winner = rot_idx[k];
      end
    end
  end

  assign grant = rst_n && (state == IDLE) && found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = grant && (winner == ID_WIDTH'(gi));
    end
  endgenerate

  assign add_a        = op_a;
  assign add_b        = op_b;
  assign add_clk_en   = rst_n && (state == EXEC);
  assign add_adder_en = add_clk_en && !op_bypass;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_bypass <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_a      <= req_a[winner*DATA_WIDTH +: DATA_WIDTH];
            op_b      <= req_b[winner*DATA_WIDTH +: DATA_WIDTH];
            op_bypass <= req_bypass[winner];
            op_id     <= winner;
            ptr       <= (winner == LAST_ID) ? '0 : winner + 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= add_result;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          // returning to IDLE first keeps the grant out of the handshake cycle
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
